// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter: round-robin sharing of one CSR port among NUM_MASTER requesters
module csr_bus_arbiter #(
    parameter int NUM_MASTER = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_MASTER-1:0]        m_req_i,
    input  logic [NUM_MASTER-1:0]        m_we_i,
    input  logic [NUM_MASTER*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTER*DATA_W-1:0] m_wdata_i,
    output logic [NUM_MASTER-1:0]        m_ack_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic [ADDR_W-1:0]            csr_addr_o,
    output logic                         csr_we_o,
    output logic [DATA_W-1:0]            csr_wdata_o,
    input  logic [DATA_W-1:0]            csr_rdata_i
);
    localparam int IDX_W = $clog2(NUM_MASTER);
    typedef enum logic [1:0] {IDLE, ADDR, READ, RESP} state_e;
    state_e state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d, idx_q, idx_d, pick;
    logic we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    // Scan from the highest offset down so the requester closest to rr wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTER-1:0] req,
                                                 input logic [IDX_W-1:0] rr);
        logic [IDX_W-1:0] p;
        int j;
        p = '0;
        for (int i = NUM_MASTER - 1; i >= 0; i--) begin
            j = int'(rr) + i;
            if (j >= NUM_MASTER) j = j - NUM_MASTER;
            if (req[IDX_W'(j)]) p = IDX_W'(j);
        end
        return p;
    endfunction
    assign pick = rr_pick(m_req_i, rr_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (|m_req_i) begin
                state_d = ADDR;
                idx_d   = pick;
                for (int k = 0; k < NUM_MASTER; k++) begin
                    if (pick == IDX_W'(k)) begin
                        we_d    = m_we_i[k];
                        addr_d  = m_addr_i[k*ADDR_W +: ADDR_W];
                        wdata_d = m_wdata_i[k*DATA_W +: DATA_W];
                    end
                end
            end
            ADDR: state_d = we_q ? RESP : READ;
            READ: begin
                rdata_d = csr_rdata_i;
                state_d = RESP;
            end
            RESP: begin
                rr_d    = (idx_q == IDX_W'(NUM_MASTER - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        m_ack_o = '0;
        if (state_q == RESP) m_ack_o[idx_q] = 1'b1;
        csr_we_o = (state_q == ADDR) && we_q;
    end
    assign csr_addr_o  = addr_q;
    assign csr_wdata_o = wdata_q;
    assign m_rdata_o   = rdata_q;
endmodule

// File: tb/tb_csr_bus_arbiter.sv
// tb_csr_bus_arbiter: directed vectors, corner sequences and a randomized
// round-robin/timing scoreboard for csr_bus_arbiter
module tb_csr_bus_arbiter;
    localparam int N = 2;
    localparam int AW = 12;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] m_req, m_we, m_ack;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata, csr_wdata, csr_rdata;
    logic [AW-1:0] csr_addr;
    logic csr_we;
    logic pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] csr_mem [0:4095];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int ptr, free_from, g, eg, ek, ka, st_cyc, strobes, wr_acks;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data, last_rd;
    logic [N-1:0] hv;
    logic r_we [N];
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_wdata [N];
    int since [N], hold [N];
    logic [DW-1:0] ref_mem [16];
    logic [N-1:0] req_hist [8192];
    typedef struct {
        int m;
        logic we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int lat;
        logic [DW-1:0] rdata;
    } vec_t;
    vec_t vt [6];

    csr_bus_arbiter #(.NUM_MASTER(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
        .m_wdata_i(m_wdata), .m_ack_o(m_ack), .m_rdata_o(m_rdata), .csr_addr_o(csr_addr),
        .csr_we_o(csr_we), .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata)
    );

    always #5 clk = ~clk;

    // CSR register file: registered read, one clk after the address
    always @(posedge clk) begin
        if (pl_we) csr_mem[pl_addr] <= pl_data;
        else if (csr_we) csr_mem[csr_addr] <= csr_wdata;
        csr_rdata <= csr_mem[csr_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_m(input int k, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [N-1:0] mk;
        mk = N'(1) << k;
        m_req = req ? (m_req | mk) : (m_req & ~mk);
        m_we  = we ? (m_we | mk) : (m_we & ~mk);
        m_addr[k*AW +: AW] = a;
        m_wdata[k*DW +: DW] = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_we = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{0, 1'b1, 12'h400, 8'h00, 2, 8'h00};
        vt[1] = '{1, 1'b0, 12'h503, 8'h00, 3, 8'hA5};
        vt[2] = '{0, 1'b1, 12'h0FF, 8'h3C, 2, 8'hA5};
        vt[3] = '{1, 1'b0, 12'h0FF, 8'h00, 3, 8'h3C};
        vt[4] = '{1, 1'b1, 12'h0FF, 8'h77, 2, 8'h3C};
        vt[5] = '{0, 1'b0, 12'h400, 8'h00, 3, 8'h00};
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        m_we = '0; m_addr = '0; m_wdata = '0;
        // reset with requests pending: nothing may leak out
        rst = 1'b1;
        m_req = '1;
        tick();
        tick();
        chk("rst_ack", 32'(m_ack), 32'(0));
        chk("rst_we", 32'(csr_we), 32'(0));
        chk("rst_addr", 32'(csr_addr), 32'(0));
        chk("rst_wdata", 32'(csr_wdata), 32'(0));
        chk("rst_rdata", 32'(m_rdata), 32'(0));
        m_req = '0;
        rst = 1'b0;
        preload(12'h503, 8'hA5);
        // single transactions from idle
        for (int v = 0; v < 6; v++) begin
            set_m(vt[v].m, 1'b1, vt[v].we, vt[v].addr, vt[v].wdata);
            for (int i = 1; i <= 5; i++) begin
                tick();
                chk($sformatf("v%0d_ack_t%0d", v, i), 32'(m_ack),
                    (i == vt[v].lat) ? 32'(1 << vt[v].m) : 32'(0));
                chk($sformatf("v%0d_we_t%0d", v, i), 32'(csr_we), (i == 1) ? 32'(vt[v].we) : 32'(0));
                if (i < vt[v].lat) chk($sformatf("v%0d_addr_t%0d", v, i), 32'(csr_addr), 32'(vt[v].addr));
                if (i == 1 && vt[v].we) chk($sformatf("v%0d_wdata", v), 32'(csr_wdata), 32'(vt[v].wdata));
                if (i == vt[v].lat) begin
                    chk($sformatf("v%0d_rdata", v), 32'(m_rdata), 32'(vt[v].rdata));
                    set_m(vt[v].m, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        // requester changes address and drops req while in ADDR
        set_m(0, 1'b1, 1'b1, 12'h010, 8'h5A);
        tick();
        chk("s4_addr", 32'(csr_addr), 32'h010);
        chk("s4_we", 32'(csr_we), 32'(1));
        chk("s4_wdata", 32'(csr_wdata), 32'h5A);
        set_m(0, 1'b0, 1'b0, 12'h020, 8'h11);
        tick();
        chk("s4_ack", 32'(m_ack), 32'b01);
        chk("s4_addr_hold", 32'(csr_addr), 32'h010);
        tick();
        chk("s4_no_second_ack", 32'(m_ack), 32'(0));
        set_m(1, 1'b1, 1'b0, 12'h010, 8'h00);
        tick();
        chk("s4_rd_addr", 32'(csr_addr), 32'h010);
        chk("s4_rd_ack0", 32'(m_ack), 32'(0));
        tick();
        tick();
        chk("s4_rd_ack", 32'(m_ack), 32'b10);
        chk("s4_rd_data", 32'(m_rdata), 32'h5A);
        set_m(1, 1'b0, 1'b0, '0, '0);
        tick();
        // reset during a read of master 1, with the pointer moved to 1 first
        set_m(0, 1'b1, 1'b1, 12'h020, 8'h99);
        tick();
        tick();
        chk("s5_pre_ack", 32'(m_ack), 32'b01);
        set_m(0, 1'b0, 1'b0, '0, '0);
        tick();
        set_m(1, 1'b1, 1'b0, 12'h503, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        m_req = '0;
        tick();
        chk("s5_ack", 32'(m_ack), 32'(0));
        chk("s5_we", 32'(csr_we), 32'(0));
        chk("s5_addr", 32'(csr_addr), 32'(0));
        chk("s5_wdata", 32'(csr_wdata), 32'(0));
        chk("s5_rdata", 32'(m_rdata), 32'(0));
        rst = 1'b0;
        set_m(0, 1'b1, 1'b1, 12'h030, 8'h01);
        set_m(1, 1'b1, 1'b1, 12'h031, 8'h02);
        tick();
        chk("s5_grant_m0_addr", 32'(csr_addr), 32'h030);
        chk("s5_no_stale_ack", 32'(m_ack), 32'(0));
        tick();
        chk("s5_ack_m0", 32'(m_ack), 32'b01);
        set_m(0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        chk("s5_grant_m1_addr", 32'(csr_addr), 32'h031);
        tick();
        chk("s5_ack_m1", 32'(m_ack), 32'b10);
        set_m(1, 1'b0, 1'b0, '0, '0);
        tick();
        // both masters hold requests: grants alternate every 3 clks
        do_reset();
        set_m(0, 1'b1, 1'b1, 12'h040, 8'h10);
        set_m(1, 1'b1, 1'b1, 12'h041, 8'h20);
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk($sformatf("s3_ack_t%0d", i), 32'(m_ack),
                (i % 3 == 2) ? 32'(1 << ((i / 3) % 2)) : 32'(0));
        end
        m_req = '0;
        tick();
        chk("s3_idle", 32'(m_ack), 32'(0));
        // randomized traffic against a round-robin / latency reference
        do_reset();
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = 8'($urandom);
            preload(12'h7F0 + 12'(a), ref_mem[a]);
        end
        ptr = 0; free_from = cyc; last_rd = 8'h00; strobes = 0; wr_acks = 0; st_cyc = -1;
        st_addr = '0; st_data = '0;
        for (int k = 0; k < N; k++) begin
            hold[k] = 0;
            since[k] = 0;
            r_we[k] = 1'b0;
            r_addr[k] = '0;
            r_wdata[k] = '0;
        end
        for (int t = 0; t < 2000; t++) begin
            for (int k = 0; k < N; k++) begin
                if (!m_req[k]) begin
                    if (hold[k] > 0) hold[k]--;
                    else if (t < 1980 && $urandom_range(0, 2) == 0) begin
                        r_we[k] = 1'($urandom_range(0, 1));
                        r_addr[k] = 12'h7F0 + 12'($urandom_range(0, 15));
                        r_wdata[k] = 8'($urandom);
                        set_m(k, 1'b1, r_we[k], r_addr[k], r_wdata[k]);
                        since[k] = cyc;
                    end
                end
            end
            req_hist[cyc] = m_req;
            tick();
            if (csr_we) begin
                strobes++;
                st_cyc = cyc;
                st_addr = csr_addr;
                st_data = csr_wdata;
            end
            chk("ack_onehot", 32'($countones(m_ack) <= 1), 32'(1));
            if (m_ack != '0) begin
                ka = 0;
                for (int k = 0; k < N; k++) if (m_ack[k]) ka = k;
                g = cyc - (r_we[ka] ? 2 : 3);
                eg = -1;
                for (int c = free_from; c < cyc && eg < 0; c++) if (req_hist[c] != '0) eg = c;
                chk("grant_cycle", 32'(g), 32'(eg));
                ek = -1;
                if (eg >= 0) begin
                    for (int o = N - 1; o >= 0; o--) begin
                        hv = req_hist[eg] >> ((ptr + o) % N);
                        if (hv[0]) ek = (ptr + o) % N;
                    end
                end
                chk("rr_winner", 32'(ka), 32'(ek));
                if (r_we[ka]) begin
                    wr_acks++;
                    chk("strobe_cycle", 32'(st_cyc), 32'(cyc - 1));
                    chk("strobe_addr", 32'(st_addr), 32'(r_addr[ka]));
                    chk("strobe_data", 32'(st_data), 32'(r_wdata[ka]));
                    ref_mem[r_addr[ka][3:0]] = r_wdata[ka];
                    chk("rdata_hold", 32'(m_rdata), 32'(last_rd));
                end else begin
                    last_rd = ref_mem[r_addr[ka][3:0]];
                    chk("rdata", 32'(m_rdata), 32'(last_rd));
                end
                ptr = (ka + 1) % N;
                free_from = cyc + 1;
                set_m(ka, 1'b0, 1'b0, r_addr[ka], r_wdata[ka]);
                hold[ka] = int'($urandom_range(2, 5));
            end
            for (int k = 0; k < N; k++) begin
                if (m_req[k] && cyc - since[k] > 24) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL ack_timeout master %0d: waited %0d cycles, required within 24", k, cyc - since[k]);
                    set_m(k, 1'b0, 1'b0, '0, '0);
                    hold[k] = 2;
                end
            end
        end
        chk("strobe_count", 32'(strobes), 32'(wr_acks));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
